// File: rtl/cpu_controller_pkg.sv
// Shared definitions for the accumulator CPU: opcode and phase encodings,
// controller state, and the ALU-operation membership helper.
package cpu_pkg;

  typedef enum logic [2:0] {
    OP_HLT = 3'd0,
    OP_SKZ = 3'd1,
    OP_ADD = 3'd2,
    OP_AND = 3'd3,
    OP_XOR = 3'd4,
    OP_LDA = 3'd5,
    OP_STO = 3'd6,
    OP_JMP = 3'd7
  } opcode_t;

  typedef enum logic [2:0] {
    INST_ADDR  = 3'd0,
    INST_FETCH = 3'd1,
    INST_LOAD  = 3'd2,
    IDLE       = 3'd3,
    OP_ADDR    = 3'd4,
    OP_FETCH   = 3'd5,
    ALU_OP     = 3'd6,
    STORE      = 3'd7
  } phase_t;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } state_t;

  // Opcodes that read an operand from memory into the accumulator path.
  function automatic logic is_aluop(opcode_t op);
    return (op == OP_ADD) || (op == OP_AND) || (op == OP_XOR) || (op == OP_LDA);
  endfunction

endpackage

// File: rtl/cpu_controller_if.sv
// Controller <-> datapath signal bundle. The controller (master) consumes the
// opcode and zero flag and drives every datapath strobe.
interface cpu_controller_if;
  import cpu_pkg::*;

  opcode_t    opcode;
  logic       zero;
  logic       sel;
  logic       rd;
  logic       load_ir;
  logic       inc_pc;
  logic       load_pc;
  logic       load_ac;
  logic       wr;
  logic       data_e;
  logic       halt;
  logic [2:0] phase;

  modport master (
    input  opcode, zero,
    output sel, rd, load_ir, inc_pc, load_pc, load_ac, wr, data_e, halt, phase
  );

  modport slave (
    output opcode, zero,
    input  sel, rd, load_ir, inc_pc, load_pc, load_ac, wr, data_e, halt, phase
  );

endinterface

// File: rtl/cpu_controller.sv
// Eight-phase instruction sequencer. A RUN/HALTED state plus a free-running
// phase counter; all strobes are decoded combinationally from state, phase,
// opcode and zero, so an asynchronous reset takes effect on the outputs
// without waiting for a clock edge.
module cpu_controller
  import cpu_pkg::*;
#(
  parameter int NPHASE = 8
) (
  input  logic             clk,
  input  logic             rst,
  cpu_controller_if.master bus
);

  state_t state_reg, state_next;
  phase_t phase_reg, phase_next;

  logic sel, rd, load_ir, inc_pc, load_pc, load_ac, wr, data_e, halt;
  logic alu, is_skz, is_sto, is_jmp;

  assign alu    = is_aluop(bus.opcode);
  assign is_skz = (bus.opcode == OP_SKZ);
  assign is_sto = (bus.opcode == OP_STO);
  assign is_jmp = (bus.opcode == OP_JMP);

  // State and phase registers; reset restarts at the instruction fetch.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= RUN;
      phase_reg <= INST_ADDR;
    end else begin
      state_reg <= state_next;
      phase_reg <= phase_next;
    end
  end

  // Next-state logic and strobe decode for the current phase.
  always_comb begin
    state_next = state_reg;
    phase_next = phase_reg;
    sel        = 1'b0;
    rd         = 1'b0;
    load_ir    = 1'b0;
    inc_pc     = 1'b0;
    load_pc    = 1'b0;
    load_ac    = 1'b0;
    wr         = 1'b0;
    data_e     = 1'b0;
    halt       = 1'b0;

    if (state_reg == HALTED) begin
      // Parked: only reset leaves this state, phase stays at 0.
      halt       = 1'b1;
      phase_next = INST_ADDR;
    end else begin
      phase_next = phase_t'(phase_reg + 3'd1);
      case (phase_reg)
        INST_ADDR: begin
          sel = 1'b1;
        end
        INST_FETCH: begin
          sel = 1'b1;
          rd  = 1'b1;
        end
        INST_LOAD, IDLE: begin
          sel     = 1'b1;
          rd      = 1'b1;
          load_ir = 1'b1;
        end
        OP_ADDR: begin
          if (bus.opcode == OP_HLT) begin
            halt       = 1'b1;
            state_next = HALTED;
            phase_next = INST_ADDR;
          end else begin
            inc_pc = 1'b1;
          end
        end
        OP_FETCH: begin
          rd = alu;
        end
        ALU_OP: begin
          // zero is only consulted here: a SKZ skip is the second PC bump.
          rd      = alu;
          load_ac = alu;
          inc_pc  = is_skz && bus.zero;
          load_pc = is_jmp;
          data_e  = is_sto;
        end
        STORE: begin
          // data_e stays up around the write so the bus is driven throughout.
          rd      = alu;
          load_ac = alu;
          load_pc = is_jmp;
          wr      = is_sto;
          data_e  = is_sto;
        end
        default: begin
          sel = 1'b0;
        end
      endcase
    end
  end

  assign bus.sel     = sel;
  assign bus.rd      = rd;
  assign bus.load_ir = load_ir;
  assign bus.inc_pc  = inc_pc;
  assign bus.load_pc = load_pc;
  assign bus.load_ac = load_ac;
  assign bus.wr      = wr;
  assign bus.data_e  = data_e;
  assign bus.halt    = halt;
  assign bus.phase   = phase_reg;

  // Datapath safety invariants and phase range.
  assert property (@(posedge clk) disable iff (!rst) !(inc_pc && load_pc));
  assert property (@(posedge clk) disable iff (!rst) (!wr || data_e));
  assert property (@(posedge clk) disable iff (!rst) (int'(phase_reg) < NPHASE));

endmodule

// File: tb/tb_cpu_controller.sv
// Randomized bench for cpu_controller: a cycle-level reference model tracks
// phase and halt status and derives the expected strobes from the phase rules.
module tb_cpu_controller;
  import cpu_pkg::*;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;
  int   m_phase;
  bit   m_halted;

  cpu_controller_if bus ();

  cpu_controller #(.NPHASE(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (phase %0d)", tag, got, exp, m_phase);
    end
  endtask

  // Expected {sel,rd,load_ir,inc_pc,load_pc,load_ac,wr,data_e,halt,phase}.
  function automatic logic [11:0] model_vec(int ph, bit hlt, int op, logic z);
    logic alu;
    logic s, r, li, ip, lp, la, w, de, h;
    if (hlt) return {9'b000000001, 3'd0};
    alu = (op >= 2) && (op <= 5);
    s   = (ph <= 3);
    r   = ((ph >= 1) && (ph <= 3)) || ((ph >= 5) && alu);
    li  = (ph == 2) || (ph == 3);
    ip  = ((ph == 4) && (op != 0)) || ((ph == 6) && (op == 1) && (z == 1'b1));
    lp  = (ph >= 6) && (op == 7);
    la  = (ph >= 6) && alu;
    w   = (ph == 7) && (op == 6);
    de  = (ph >= 6) && (op == 6);
    h   = (ph == 4) && (op == 0);
    return {s, r, li, ip, lp, la, w, de, h, 3'(ph)};
  endfunction

  function automatic logic [11:0] dut_vec();
    return {bus.sel, bus.rd, bus.load_ir, bus.inc_pc, bus.load_pc, bus.load_ac,
            bus.wr, bus.data_e, bus.halt, bus.phase};
  endfunction

  // Check outputs mid-cycle, then advance the model at the rising edge.
  task automatic step(input string tag);
    @(negedge clk);
    check_val(tag, 32'(dut_vec()), 32'(model_vec(m_phase, m_halted, int'(bus.opcode), bus.zero)));
    @(posedge clk);
    #1;
    if (!rst) begin
      m_phase  = 0;
      m_halted = 1'b0;
    end else if (!m_halted) begin
      if (m_phase == 4 && bus.opcode == OP_HLT) begin
        m_halted = 1'b1;
        m_phase  = 0;
      end else begin
        m_phase = (m_phase + 1) % 8;
      end
    end
  endtask

  // One full instruction; zmode 0/1 holds zero fixed, 2 randomizes it per cycle.
  task automatic run_instr(input opcode_t op, input int zmode, input string tag);
    bus.opcode = op;
    for (int i = 0; i < 8; i++) begin
      bus.zero = (zmode == 2) ? 1'($urandom) : 1'(zmode);
      step(tag);
    end
    $display("instr %s opcode=%0d checks=%0d errors=%0d", tag, int'(op), n_checks, n_errors);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    m_phase  = 0;
    m_halted = 1'b0;
    rst      = 1'b0;
    bus.opcode = opcode_t'(3'($urandom));
    bus.zero   = 1'b0;

    // Held in reset for three cycles, then released.
    for (int i = 0; i < 3; i++) step("reset_hold");
    rst = 1'b1;
    $display("reset released at %0t", $time);

    run_instr(OP_ADD, 0, "add");
    run_instr(OP_SKZ, 1, "skz_zero1");
    run_instr(OP_SKZ, 0, "skz_zero0");
    run_instr(OP_STO, 2, "sto");
    run_instr(OP_JMP, 2, "jmp");

    for (int n = 0; n < 40; n++)
      run_instr(opcode_t'(3'($urandom_range(1, 7))), 2, "random");

    // HLT: phases 0..4 then parked for 20 cycles.
    bus.opcode = OP_HLT;
    for (int i = 0; i < 5; i++) step("hlt_enter");
    for (int i = 0; i < 20; i++) begin
      bus.opcode = opcode_t'(3'($urandom));
      bus.zero   = 1'($urandom);
      step("halted");
    end
    $display("instr hlt parked checks=%0d errors=%0d", n_checks, n_errors);

    // Reset pulse out of HALTED, checked before the next clock edge.
    #2;
    rst = 1'b0;
    m_phase  = 0;
    m_halted = 1'b0;
    #1;
    check_val("halt_rst_async", 32'(dut_vec()), 32'(model_vec(0, 1'b0, int'(bus.opcode), bus.zero)));
    step("halt_rst_hold");
    rst = 1'b1;
    run_instr(OP_LDA, 2, "resume_lda");
    run_instr(OP_XOR, 2, "resume_xor");

    // Drop reset during phase 6 of a STO; the write must never appear.
    bus.opcode = OP_STO;
    bus.zero   = 1'b0;
    for (int i = 0; i < 6; i++) step("sto_pre_rst");
    @(negedge clk);
    check_val("sto_phase6", 32'(dut_vec()), 32'(model_vec(6, 1'b0, int'(OP_STO), 1'b0)));
    #2;
    rst = 1'b0;
    m_phase  = 0;
    m_halted = 1'b0;
    #1;
    check_val("midrst_async", 32'(dut_vec()), 32'(model_vec(0, 1'b0, int'(OP_STO), 1'b0)));
    check_val("midrst_wr", 32'(bus.wr), 32'd0);
    @(posedge clk);
    #1;
    step("midrst_hold");
    rst = 1'b1;
    run_instr(OP_AND, 2, "post_rst_and");
    run_instr(OP_SKZ, 1, "post_rst_skz");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cpu_controller.md
# cpu_controller

Instruction sequencer for the 8-bit accumulator CPU. It sits downstream of the instruction register: it consumes the 3-bit opcode and the accumulator zero flag, and it drives every load, increment, memory and bus-enable strobe in the datapath. These include `load_pc`/`inc_pc` to the program counter, `load_ir` to the instruction register, accumulator load, and memory read/write. Every instruction takes a fixed eight-phase cycle. HLT parks the CPU until reset.

## Interface
Parameters:
- `NPHASE`, 8: phases per instruction. Fixed; it exists only for documentation and assertions.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `opcode`  in  3  opcode field from the instruction register.
- `zero`  in  1  accumulator-is-zero flag.
- `sel`  out  1  address mux select: 1 = PC address, 0 = IR operand address.
- `rd`  out  1  memory read enable.
- `load_ir`  out  1  instruction register load.
- `inc_pc`  out  1  program counter increment.
- `load_pc`  out  1  program counter load from the IR address.
- `load_ac`  out  1  accumulator load.
- `wr`  out  1  memory write strobe.
- `data_e`  out  1  accumulator drive enable onto the memory data bus.
- `halt`  out  1  CPU halted.
- `phase`  out  3  current phase, for debug and the testbench. Reads 0 while halted.

## Operation
- Opcodes:
  - HLT=0, SKZ=1, ADD=2, AND=3, XOR=4, LDA=5, STO=6, JMP=7.
  - ALUOP = ADD, AND, XOR or LDA.
- State is `RUN` or `HALTED`, plus a 3-bit phase counter. The counter advances by one per cycle in `RUN` and wraps 7→0.
- The phases are INST_ADDR(0), INST_FETCH(1), INST_LOAD(2), IDLE(3), OP_ADDR(4), OP_FETCH(5), ALU_OP(6) and STORE(7).
- Outputs are combinational from (state, phase, opcode, zero). Any output not listed for a phase is 0.
  - 0: `sel`.
  - 1: `sel`, `rd`.
  - 2: `sel`, `rd`, `load_ir`.
  - 3: `sel`, `rd`, `load_ir`.
  - 4:
    - if HLT: `halt`=1, and there is no `inc_pc`;
    - otherwise `inc_pc`=1.
  - 5: `rd`=ALUOP.
  - 6: `rd`=ALUOP, `load_ac`=ALUOP, `inc_pc`=SKZ&&zero, `load_pc`=JMP, `data_e`=STO.
  - 7: `rd`=ALUOP, `load_ac`=ALUOP, `load_pc`=JMP, `wr`=STO, `data_e`=STO.
- HLT transition: at phase 4 with opcode HLT, the next state is `HALTED`.
- In `HALTED`:
  - `halt`=1 and all other strobes are 0;
  - `phase` holds 0;
  - the block leaves only on reset.
- Invariant: `inc_pc` and `load_pc` are never both 1 in the same cycle.
- Invariant: `wr` is asserted only while `data_e`=1.

## Timing
- Reset (`rst`=0, asynchronous, in any state):
  - state becomes `RUN` and phase becomes 0 immediately;
  - outputs go to `sel`=1 with all others 0 during reset and in the first cycle after release.
- Reset in the middle of an instruction abandons it. No `wr` may be asserted after `rst` falls.
- Latency:
  - one instruction takes 8 cycles;
  - the first fetch completes at the edge that ends phase 2;
  - `opcode` is treated as valid from phase 3 onward, and phases 0–2 ignore it.
- `zero` is sampled only in phase 6. A SKZ skip therefore applies the second PC increment of the instruction in that cycle.
- HLT: `halt` rises combinationally in phase 4 and stays high from the next edge onward.
- JMP: `load_pc` is high for 2 cycles (phases 6–7). The PC reloads the same address twice, which is harmless.
- The phase counter wraps 7→0 with no idle gap between instructions.

## Structure
- Shared package `cpu_pkg`:
  - `opcode_t` enum (3 bits, values as above);
  - `phase_t` enum (3 bits);
  - `ALUOP` membership as a function `is_aluop(opcode_t)`.
  - The instruction register and the ALU import the same package.
- No sub-module. The design is one always_ff for state and phase, plus one always_comb output decoder.

## Test plan
- Reset state: hold `rst`=0 for 3 cycles, then release. Require `sel`=1, all other strobes 0 and `phase`=0; then `phase` steps 0..7,0 on successive cycles.
- ADD: `opcode`=2, `zero`=0. Require `inc_pc` only in phase 4, `rd`=1 in phases 5–7, `load_ac`=1 in phases 6–7, and `wr`=0 throughout.
- SKZ: `opcode`=1.
  - With `zero`=1: `inc_pc`=1 in phases 4 and 6.
  - With `zero`=0: `inc_pc`=1 in phase 4 only.
- STO then JMP:
  - `opcode`=6: `data_e`=1 in phases 6–7 and `wr`=1 in phase 7 only.
  - `opcode`=7: `load_pc`=1 in phases 6–7 and `inc_pc`=0 in both.
- HLT: `opcode`=0.
  - `halt`=1 in phase 4 with `inc_pc`=0.
  - Over the next 20 cycles, `halt` stays 1, every other strobe is 0 and `phase`=0.
  - Then `rst` pulses low and the block resumes at phase 0 with `sel`=1.
- Mid-instruction reset: drop `rst` during phase 6 of a STO. Require `wr` never asserted, and the outputs reset asynchronously before the next clock edge.
